uart_piso: RTL and testbench

//  UART transmit shift stage: latches a pre-built frame (start, data, parity, stop bits)
//  and shifts it out LSB-first, one bit per baud_out cycle. Sits after the frame generator
//  and baud generator in the UART TX path. Also reports the computed data parity and status.

---
 rtl/uart_piso_if.sv | 22 ++
 rtl/uart_piso.sv | 106 ++++++++++
 tb/tb_uart_piso.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_piso_if.sv
// UART TX shift-stage bus: frame, run-time config, start request and serial/status outputs.
interface uart_piso_if;
    logic [11:0] frame_out;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        data_length;
    logic        send;
    logic        data_out;
    logic        P_parity_out;
    logic        tx_active;
    logic        tx_done;

    modport master (
        output frame_out, parity_type, stop_bits, data_length, send,
        input  data_out, P_parity_out, tx_active, tx_done
    );

    modport slave (
        input  frame_out, parity_type, stop_bits, data_length, send,
        output data_out, P_parity_out, tx_active, tx_done
    );
endinterface

// File: rtl/uart_piso.sv
// UART TX shift stage: latches a 9..12 bit frame on a send rising edge and shifts it out LSB-first.
// Optional macro PISO_PARITY_OVERRIDE_EN replaces the transmitted parity bit with the computed one.
module uart_piso (
    input  logic         baud_out,
    input  logic         rst,
    uart_piso_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      r_state;
    state_e      w_next_state;
    logic        r_send_prev;
    logic [11:0] r_frame;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic        r_parity;

    logic        w_send_rise;
    logic        w_par_en;
    logic [7:0]  w_data_bits;
    logic        w_parity;
    logic [3:0]  w_len;
    logic [11:0] w_frame_ld;
    logic        w_data_out;
    logic        w_tx_active;
    logic        w_tx_done;

    assign w_send_rise = bus.send & ~r_send_prev;

    // Frame decode from the live inputs; only consumed on the latching cycle.
    always_comb begin
        w_par_en    = (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
        w_data_bits = bus.data_length ? bus.frame_out[8:1] : {1'b0, bus.frame_out[7:1]};
        w_parity    = 1'b0;
        if (bus.parity_type == 2'b01) begin
            w_parity = ~(^w_data_bits);
        end else if (bus.parity_type == 2'b10) begin
            w_parity = ^w_data_bits;
        end
        w_len = 4'd1 + (bus.data_length ? 4'd8 : 4'd7) + {3'b000, w_par_en}
              + (bus.stop_bits ? 4'd2 : 4'd1);
        w_frame_ld = bus.frame_out;
`ifdef PISO_PARITY_OVERRIDE_EN
        if (w_par_en) begin
            if (bus.data_length) begin
                w_frame_ld[9] = w_parity;
            end else begin
                w_frame_ld[8] = w_parity;
            end
        end
`endif
    end

    always_comb begin
        w_next_state = r_state;
        w_data_out   = 1'b1;
        w_tx_active  = 1'b0;
        w_tx_done    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_send_rise) begin
                    w_next_state = StShift;
                end
            end
            StShift: begin
                w_data_out  = r_frame[r_idx];
                w_tx_active = 1'b1;
                if (r_idx == r_len - 4'd1) begin
                    w_next_state = StDone;
                end
            end
            StDone: begin
                w_tx_done    = 1'b1;
                w_next_state = StIdle;
            end
            default: w_next_state = StIdle;
        endcase
    end

    always_ff @(posedge baud_out) begin
        if (rst) begin
            r_state     <= StIdle;
            r_send_prev <= 1'b0;
            r_frame     <= 12'hFFF;
            r_len       <= 4'd0;
            r_idx       <= 4'd0;
            r_parity    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_send_prev <= bus.send;
            if (r_state == StIdle && w_send_rise) begin
                r_frame  <= w_frame_ld;
                r_len    <= w_len;
                r_idx    <= 4'd0;
                r_parity <= w_parity;
            end else if (r_state == StShift) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign bus.data_out     = w_data_out;
    assign bus.tx_active    = w_tx_active;
    assign bus.tx_done      = w_tx_done;
    assign bus.P_parity_out = r_parity;
endmodule

// File: tb/tb_uart_piso.sv
// Directed bench for uart_piso: expected serial bits are queued at send time and popped per bit.
module tb_uart_piso;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    uart_piso_if bus ();

    uart_piso dut (
        .baud_out (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent frame model: pushes the N expected line bits and returns the expected parity.
    task automatic model(input logic [11:0] f, input logic [1:0] pt, input logic sb,
                         input logic dl, output logic par, output int n);
        int   d;
        int   p;
        logic x;
        logic [11:0] fr;
        d  = dl ? 8 : 7;
        p  = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
        n  = 1 + d + p + (sb ? 2 : 1);
        x  = 1'b0;
        for (int i = 1; i <= d; i++) x = x ^ f[i];
        par = (pt == 2'b10) ? x : (pt == 2'b01) ? ~x : 1'b0;
        fr = f;
`ifdef PISO_PARITY_OVERRIDE_EN
        if (p == 1) fr[d+1] = par;
`endif
        for (int i = 0; i < n; i++) exp_q.push_back(fr[i]);
    endtask

    task automatic run_frame(input string tag, input logic [11:0] f, input logic [1:0] pt,
                             input logic sb, input logic dl);
        logic par;
        int   n;
        bus.send        = 1'b0;
        bus.frame_out   = f;
        bus.parity_type = pt;
        bus.stop_bits   = sb;
        bus.data_length = dl;
        @(negedge clk);
        bus.send = 1'b1;
        model(f, pt, sb, dl, par, n);
        @(negedge clk);
        // Scramble everything after the latch; the frame in flight must not change.
        bus.frame_out   = ~f;
        bus.parity_type = ~pt;
        bus.stop_bits   = ~sb;
        bus.data_length = ~dl;
        bus.send        = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s bit%0d", tag, i), {11'd0, bus.data_out}, {11'd0, exp_q.pop_front()});
            chk($sformatf("%s active%0d", tag, i), {11'd0, bus.tx_active}, 12'd1);
            if (i == 2) bus.send = 1'b1;
            @(negedge clk);
        end
        chk({tag, " done"}, {11'd0, bus.tx_done}, 12'd1);
        chk({tag, " done_inactive"}, {11'd0, bus.tx_active}, 12'd0);
        chk({tag, " done_line"}, {11'd0, bus.data_out}, 12'd1);
        chk({tag, " parity"}, {11'd0, bus.P_parity_out}, {11'd0, par});
        @(negedge clk);
        chk({tag, " idle_done"}, {11'd0, bus.tx_done}, 12'd0);
        chk({tag, " idle_line"}, {11'd0, bus.data_out}, 12'd1);
        chk({tag, " parity_hold"}, {11'd0, bus.P_parity_out}, {11'd0, par});
    endtask

    initial begin
        rst             = 1'b1;
        bus.send        = 1'b0;
        bus.frame_out   = 12'h000;
        bus.parity_type = 2'b00;
        bus.stop_bits   = 1'b0;
        bus.data_length = 1'b0;
        @(negedge clk);
        chk("rst line", {11'd0, bus.data_out}, 12'd1);
        chk("rst active", {11'd0, bus.tx_active}, 12'd0);
        chk("rst done", {11'd0, bus.tx_done}, 12'd0);
        chk("rst parity", {11'd0, bus.P_parity_out}, 12'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame("t2", 12'h2AA, 2'b00, 1'b0, 1'b1);
        run_frame("t3", 12'h766, 2'b01, 1'b1, 1'b0);
        run_frame("t4", 12'h54A, 2'b10, 1'b0, 1'b1);
        run_frame("t5", 12'h9D5, 2'b11, 1'b1, 1'b1);
        // send is still held high here: no retrigger.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold idle%0d", i), {bus.tx_active, bus.tx_done, bus.data_out}, 12'd1);
        end
        // Shortest frame with junk above bit 8.
        run_frame("short", 12'hE5A, 2'b00, 1'b0, 1'b0);
        run_frame("odd8", 12'h3C7, 2'b01, 1'b0, 1'b1);

        // Reset mid-frame at bit 4.
        bus.send        = 1'b0;
        bus.frame_out   = 12'h0F0;
        bus.parity_type = 2'b10;
        bus.stop_bits   = 1'b1;
        bus.data_length = 1'b1;
        @(negedge clk);
        bus.send = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("abort bit4", {11'd0, bus.data_out}, 12'd1);
        chk("abort active", {11'd0, bus.tx_active}, 12'd1);
        rst      = 1'b1;
        bus.send = 1'b0;
        @(negedge clk);
        chk("abort line", {11'd0, bus.data_out}, 12'd1);
        chk("abort inactive", {11'd0, bus.tx_active}, 12'd0);
        chk("abort no_done", {11'd0, bus.tx_done}, 12'd0);
        chk("abort parity", {11'd0, bus.P_parity_out}, 12'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort%0d", i), {bus.tx_active, bus.tx_done, bus.data_out}, 12'd1);
        end
        run_frame("t6", 12'h0F0, 2'b10, 1'b1, 1'b1);

        chk("queue empty", exp_q.size(), 12'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
